// File: rtl/piso_tx_if.sv
// -----------------------------------------------------------------------------
// piso_tx_if -- word-in / bit-out bundle for the piso_tx transmitter.
//
// Signals:
//   in_data   [WIDTH-1:0]  parallel word from the producer
//   in_valid               producer has a word on in_data
//   in_ready               transmitter can take a word this cycle
//   out                    serial data bit
//   out_valid              out carries a frame bit this cycle
//   out_last               out carries the final bit of the frame
//
// Modports:
//   master -- producer / serial sink side (drives in_data, in_valid)
//   slave  -- the transmitter itself
// -----------------------------------------------------------------------------
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             out_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, out, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out, out_valid, out_last
  );
endinterface

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out transmitter.
//
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out one bit
// per clock, qualified by out_valid, with out_last on the final bit. A new word
// can be accepted during the last bit of a frame, so frames run back to back
// with no idle gap.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   piso_tx_if.slave: in_data/in_valid/in_ready handshake in,
//         out/out_valid/out_last serial stream out (all outputs registered
//         except in_ready, which is combinational)
//
// Parameters:
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1 = transmit bit WIDTH-1 first, 0 = bit 0 first
//
// Build option:
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the word, taken
//                   at accept) is appended after the data bits and carries
//                   out_last.
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  piso_tx_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLEN);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_q,       out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q,    parity_d;
`endif

  logic             accept;
  logic             load_bit;
  logic [WIDTH-1:0] load_shift;
  logic             next_bit;
  logic [WIDTH-1:0] next_shift;

  // Ready in IDLE, or while the last bit of a frame is on the line so the next
  // word follows without a gap. Held low during reset.
  assign bus.in_ready = !rst &&
                        ((state_q == IDLE) ||
                         ((state_q == SHIFT) && (cnt_q == CNT_LAST)));
  assign accept       = bus.in_valid && bus.in_ready;

  // The register always holds the bits still to be sent, aligned so the next
  // one sits at the transmit end.
  always_comb begin
    if (MSB_FIRST) begin
      load_bit   = bus.in_data[WIDTH-1];
      load_shift = bus.in_data << 1;
      next_bit   = shift_q[WIDTH-1];
      next_shift = shift_q << 1;
    end else begin
      load_bit   = bus.in_data[0];
      load_shift = bus.in_data >> 1;
      next_bit   = shift_q[0];
      next_shift = shift_q >> 1;
    end
  end

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    if (accept) begin
      // Start (or chain) a frame: first bit goes out on the next cycle.
      state_d     = SHIFT;
      shift_d     = load_shift;
      out_d       = load_bit;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      cnt_d       = CNT_ONE;
`ifdef PISO_PARITY_EN
      parity_d    = ^bus.in_data;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q != CNT_LAST) begin
        shift_d    = next_shift;
        out_d      = next_bit;
`ifdef PISO_PARITY_EN
        // Data exhausted: the appended bit is the stored parity.
        if (cnt_q == CNT_W'(WIDTH)) begin
          out_d = parity_q;
        end
`endif
        cnt_d      = cnt_q + CNT_ONE;
        out_last_d = (cnt_q == (CNT_LAST - CNT_ONE));
      end else begin
        // Frame done and nothing waiting: return the line to idle-low.
        state_d     = IDLE;
        cnt_d       = '0;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the shift register is reset along with the control state so that a
  // frame aborted by reset leaves no stale bits behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx -- directed bench for piso_tx.
//
// Two instances share clk/rst: dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// packed as {out, out_valid, out_last, in_ready}. Expected frames are written
// out by hand, with the parity bit appended when PISO_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FLEN = W + 1;
  localparam logic [FLEN-1:0] EXP_A5     = 9'b10100101_0;
  localparam logic [FLEN-1:0] EXP_3C     = 9'b00111100_0;
  localparam logic [FLEN-1:0] EXP_01_LSB = 9'b10000000_1;
  localparam logic [FLEN-1:0] EXP_FF     = 9'b11111111_0;
  localparam logic [FLEN-1:0] EXP_00     = 9'b00000000_0;
  localparam logic [FLEN-1:0] EXP_07     = 9'b00000111_1;
`else
  localparam int FLEN = W;
  localparam logic [FLEN-1:0] EXP_A5     = 8'b10100101;
  localparam logic [FLEN-1:0] EXP_3C     = 8'b00111100;
  localparam logic [FLEN-1:0] EXP_01_LSB = 8'b10000000;
  localparam logic [FLEN-1:0] EXP_FF     = 8'b11111111;
  localparam logic [FLEN-1:0] EXP_00     = 8'b00000000;
  localparam logic [FLEN-1:0] EXP_07     = 8'b00000111;
`endif

  // {out, out_valid, out_last, in_ready}
  localparam logic [3:0] IDLE_OBS  = 4'b0001;
  localparam logic [3:0] RESET_OBS = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus_m ();
  piso_tx_if #(.WIDTH(W)) bus_l ();

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  logic [3:0] obs_m;
  logic [3:0] obs_l;
  assign obs_m = {bus_m.out, bus_m.out_valid, bus_m.out_last, bus_m.in_ready};
  assign obs_l = {bus_l.out, bus_l.out_valid, bus_l.out_last, bus_l.in_ready};

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst            = 1'b1;
    bus_m.in_valid = 1'b0;
    bus_m.in_data  = '0;
    bus_l.in_valid = 1'b0;
    bus_l.in_data  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_m !== RESET_OBS) begin
        miscompares++;
        $display("FAIL reset_msb cycle %0d: got %b expected %b", i, obs_m, RESET_OBS);
      end
      vectors++;
      if (obs_l !== RESET_OBS) begin
        miscompares++;
        $display("FAIL reset_lsb cycle %0d: got %b expected %b", i, obs_l, RESET_OBS);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL reset_release_msb: got %b expected %b", obs_m, IDLE_OBS);
    end
    vectors++;
    if (obs_l !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL reset_release_lsb: got %b expected %b", obs_l, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One frame on the MSB-first instance; in_data is scribbled after accept to
  // show the frame in flight is unaffected.
  task automatic test_single_msb(input logic [W-1:0] word,
                                 input logic [FLEN-1:0] frame,
                                 input string name);
    logic [FLEN-1:0] e;
    logic [3:0]      exp;
    e = frame;
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = word;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    bus_m.in_data  = ~word;
    for (int i = 0; i < FLEN; i++) begin
      if (i != 0) @(negedge clk);
      exp = {e[FLEN-1-i], 1'b1, (i == FLEN-1), (i == FLEN-1)};
      vectors++;
      if (obs_m !== exp) begin
        miscompares++;
        $display("FAIL %s bit %0d: got %b expected %b", name, i, obs_m, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL %s idle_after: got %b expected %b", name, obs_m, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [2*FLEN-1:0] e;
    logic [3:0]        exp;
    logic              last;
    e = {EXP_A5, EXP_3C};
    @(negedge clk);
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL b2b idle_before: got %b expected %b", obs_m, IDLE_OBS);
    end
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = 8'hA5;
    @(negedge clk);
    bus_m.in_data  = 8'h3C;
    for (int i = 0; i < 2*FLEN; i++) begin
      if (i != 0) @(negedge clk);
      last = (i == FLEN-1) || (i == 2*FLEN-1);
      exp  = {e[2*FLEN-1-i], 1'b1, last, last};
      vectors++;
      if (obs_m !== exp) begin
        miscompares++;
        $display("FAIL b2b bit %0d: got %b expected %b", i, obs_m, exp);
      end
      if (i == 2*FLEN-1) bus_m.in_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL b2b idle_after: got %b expected %b", obs_m, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lsb_first();
    logic [FLEN-1:0] e;
    logic [3:0]      exp;
    e = EXP_01_LSB;
    @(negedge clk);
    bus_l.in_valid = 1'b1;
    bus_l.in_data  = 8'h01;
    @(negedge clk);
    bus_l.in_valid = 1'b0;
    bus_l.in_data  = 8'h00;
    for (int i = 0; i < FLEN; i++) begin
      if (i != 0) @(negedge clk);
      exp = {e[FLEN-1-i], 1'b1, (i == FLEN-1), (i == FLEN-1)};
      vectors++;
      if (obs_l !== exp) begin
        miscompares++;
        $display("FAIL lsb_01 bit %0d: got %b expected %b", i, obs_l, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs_l !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL lsb_01 idle_after: got %b expected %b", obs_l, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  // 8'h00 is offered with in_valid=1 while 8'hFF is in flight; it must only be
  // taken on the last bit, so the first frame stays all ones.
  task automatic test_busy_reject();
    logic [2*FLEN-1:0] e;
    logic [3:0]        exp;
    logic              last;
    e = {EXP_FF, EXP_00};
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = 8'hFF;
    @(negedge clk);
    bus_m.in_data  = 8'h00;
    for (int i = 0; i < 2*FLEN; i++) begin
      if (i != 0) @(negedge clk);
      last = (i == FLEN-1) || (i == 2*FLEN-1);
      exp  = {e[2*FLEN-1-i], 1'b1, last, last};
      vectors++;
      if (obs_m !== exp) begin
        miscompares++;
        $display("FAIL busy bit %0d: got %b expected %b", i, obs_m, exp);
      end
      if (i == FLEN) bus_m.in_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL busy idle_after: got %b expected %b", obs_m, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_frame();
    logic [FLEN-1:0] e;
    logic [3:0]      exp;
    e = EXP_A5;
    @(negedge clk);
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = 8'hA5;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      exp = {e[FLEN-1-i], 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs_m !== exp) begin
        miscompares++;
        $display("FAIL rst_mid pre bit %0d: got %b expected %b", i, obs_m, exp);
      end
    end
    // Assert reset between clock edges: outputs must clear with no edge.
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (obs_m !== RESET_OBS) begin
      miscompares++;
      $display("FAIL rst_mid async_clear: got %b expected %b", obs_m, RESET_OBS);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_m !== RESET_OBS) begin
      miscompares++;
      $display("FAIL rst_mid held: got %b expected %b", obs_m, RESET_OBS);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs_m !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL rst_mid no_resume: got %b expected %b", obs_m, IDLE_OBS);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_msb(8'hA5, EXP_A5, "msb_a5");
    test_back_to_back();
    test_lsb_first();
    test_busy_reject();
    test_reset_mid_frame();
    test_single_msb(8'h3C, EXP_3C, "post_rst_3c");
    test_single_msb(8'h07, EXP_07, "word_07");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
